// File: rtl/ifft4_stream.sv
// Streaming 4-point inverse FFT: gathers four 36-bit bins, applies the radix-4
// inverse butterfly with 1/4 scaling and saturation, drains four 32-bit samples.
module ifft4_stream #(
  parameter int IN_W        = 18,
  parameter int OUT_W       = 16,
  parameter int SCALE_SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [2*IN_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  output logic [2*OUT_W-1:0]   out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 err_frame,
  output logic                 sat_flag
);

  // state      | meaning
  // S_FILL     | accepting bins into the frame buffer
  // S_HOLD     | frame complete, waiting for the output bank to free up
  // S_IDLE     | output bank empty
  // S_DRAIN    | presenting obank[n_cnt] downstream
  typedef enum logic {S_FILL, S_HOLD} in_state_t;
  typedef enum logic {S_IDLE, S_DRAIN} out_state_t;

  localparam int SW = IN_W + 2;
  localparam logic signed [SW-1:0] MAX_V = SW'((1 <<< (OUT_W-1)) - 1);
  localparam logic signed [SW-1:0] MIN_V = SW'(-(1 <<< (OUT_W-1)));

  in_state_t          in_state_q, in_state_d;
  out_state_t         out_state_q, out_state_d;
  logic [1:0]         k_cnt_q, k_cnt_d;
  logic [1:0]         n_cnt_q, n_cnt_d;
  logic [2*IN_W-1:0]  bin_q [4];
  logic [2*IN_W-1:0]  bin_d [4];
  logic [2*OUT_W-1:0] obank_q [4];
  logic [2*OUT_W-1:0] obank_d [4];
  logic [2*OUT_W-1:0] res [4];
  logic               res_sat;
  logic               err_q, err_d;
  logic               sat_q, sat_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [2*OUT_W-1:0] out_data_q, out_data_d;

  logic accept_in, accept_out, transfer;

  function automatic logic is_sat(input logic signed [SW-1:0] v);
    return (v > MAX_V) || (v < MIN_V);
  endfunction

  function automatic logic [OUT_W-1:0] clip(input logic signed [SW-1:0] v);
    if (v > MAX_V)      return MAX_V[OUT_W-1:0];
    else if (v < MIN_V) return MIN_V[OUT_W-1:0];
    else                return v[OUT_W-1:0];
  endfunction

  assign accept_in  = in_valid && in_ready_q;
  assign accept_out = out_valid_q && out_ready;
  // Bank is free either when idle or when its last sample leaves this cycle.
  assign transfer   = (in_state_q == S_HOLD) &&
                      ((out_state_q == S_IDLE) ||
                       ((out_state_q == S_DRAIN) && (n_cnt_q == 2'd3) && out_ready));

  // Butterfly; multiplication by j is a swap/negate of the components.
  always_comb begin
    logic signed [SW-1:0] a [4];
    logic signed [SW-1:0] b [4];
    logic signed [SW-1:0] re_s [4];
    logic signed [SW-1:0] im_s [4];
    logic signed [SW-1:0] re_sh, im_sh;
    for (int k = 0; k < 4; k++) begin
      a[k] = {{2{bin_q[k][IN_W-1]}},   bin_q[k][IN_W-1:0]};
      b[k] = {{2{bin_q[k][2*IN_W-1]}}, bin_q[k][2*IN_W-1:IN_W]};
    end
    re_s[0] = a[0] + a[1] + a[2] + a[3];
    im_s[0] = b[0] + b[1] + b[2] + b[3];
    re_s[1] = a[0] - b[1] - a[2] + b[3];
    im_s[1] = b[0] + a[1] - b[2] - a[3];
    re_s[2] = a[0] - a[1] + a[2] - a[3];
    im_s[2] = b[0] - b[1] + b[2] - b[3];
    re_s[3] = a[0] + b[1] - a[2] - b[3];
    im_s[3] = b[0] - a[1] - b[2] + a[3];
    res_sat = 1'b0;
    for (int n = 0; n < 4; n++) begin
      re_sh   = re_s[n] >>> SCALE_SHIFT;
      im_sh   = im_s[n] >>> SCALE_SHIFT;
      res[n]  = {clip(im_sh), clip(re_sh)};
      res_sat = res_sat | is_sat(re_sh) | is_sat(im_sh);
    end
  end

  always_comb begin
    in_state_d  = in_state_q;
    out_state_d = out_state_q;
    k_cnt_d     = k_cnt_q;
    n_cnt_d     = n_cnt_q;
    bin_d       = bin_q;
    obank_d     = obank_q;
    err_d       = err_q;
    sat_d       = sat_q;

    if (accept_in) begin
      bin_d[k_cnt_q] = in_data;
      k_cnt_d        = k_cnt_q + 2'd1;
      if (k_cnt_q == 2'd3) in_state_d = S_HOLD;
      if (in_last != (k_cnt_q == 2'd3)) err_d = 1'b1;
    end

    if (transfer) begin
      in_state_d  = S_FILL;
      obank_d     = res;
      out_state_d = S_DRAIN;
      n_cnt_d     = 2'd0;
      if (res_sat) sat_d = 1'b1;
    end else if (accept_out) begin
      if (n_cnt_q == 2'd3) out_state_d = S_IDLE;
      n_cnt_d = n_cnt_q + 2'd1;
    end

    in_ready_d  = (in_state_d == S_FILL);
    out_valid_d = (out_state_d == S_DRAIN);
    out_data_d  = out_valid_d ? obank_d[n_cnt_d] : '0;
    out_last_d  = out_valid_d && (n_cnt_d == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      in_state_q  <= S_FILL;
      out_state_q <= S_IDLE;
      k_cnt_q     <= 2'd0;
      n_cnt_q     <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        bin_q[k]   <= '0;
        obank_q[k] <= '0;
      end
      err_q       <= 1'b0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      k_cnt_q     <= k_cnt_d;
      n_cnt_q     <= n_cnt_d;
      bin_q       <= bin_d;
      obank_q     <= obank_d;
      err_q       <= err_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign err_frame = err_q;
  assign sat_flag  = sat_q;

endmodule

// File: doc/ifft4_stream.md
Name: ifft4_stream

Overview:
Streaming 4-point inverse FFT. It returns frequency-domain bins, in the packed 36-bit format produced by the forward FFT4 datapath, to 16-bit packed time-domain samples. Bins arrive serially over a valid/ready handshake and are gathered into a frame buffer. The block computes the radix-4 inverse butterfly, scales by 1/4 with saturation, and drains the time samples serially with backpressure. It sits on the receive/reconstruction side, opposite the forward FFT path.

Parameters:
IN_W, 18, signed width of each real/imag component of an input bin
OUT_W, 16, signed width of each real/imag component of an output sample
SCALE_SHIFT, 2, arithmetic right shift applied after the butterfly (log2 N)

Ports:
clk  in  1  single clock, all logic rising-edge
rstn  in  1  reset: synchronous, active-low
in_data  in  2*IN_W (36)  bin {imag[35:18], real[17:0]}, two's complement
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
in_last  in  1  marks bin k=3 of a frame
out_data  out  2*OUT_W (32)  time sample {imag[31:16], real[15:0]}
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_last  out  1  high with sample n=3
err_frame  out  1  sticky: in_last mismatch detected
sat_flag  out  1  sticky: any output component saturated

Behaviour:
- Reset: one clock (clk); reset rstn is synchronous and active-low. While rstn=0 at an edge: in_ready=0, out_valid=0, out_last=0, out_data=0, err_frame=0, sat_flag=0, all counters=0, states=FILL/IDLE. Reset mid-frame discards partial input and undrained output.
- Transfers: input accept = in_valid & in_ready; output accept = out_valid & out_ready. out_data and out_last are held stable while out_valid=1 and out_ready=0.
- Input FSM FILL/HOLD:
  - FILL: in_ready=1. Each accept writes buf[k_cnt] and increments k_cnt (2 bits). An accept with k_cnt=3 wraps k_cnt to 0 and goes to HOLD.
  - HOLD: in_ready=0. Leaves to FILL at the transfer edge.
- Transfer edge: occurs when in HOLD and (output FSM IDLE, or DRAIN with n_cnt=3 and out_ready=1 in the same cycle). The butterfly result is registered into the output bank.
- Output FSM IDLE/DRAIN:
  - IDLE→DRAIN at the transfer edge, n_cnt=0.
  - DRAIN: out_valid=1, out_data=obank[n_cnt], out_last=(n_cnt==3). Each accept increments n_cnt.
  - Accept at n_cnt=3 goes to IDLE, unless a transfer occurs on the same edge, in which case it stays DRAIN with n_cnt=0 (no bubble).
- Latency: 4th bin accepted at edge t → transfer at edge t+1 (if bank free) → out_valid=1 from cycle t+1. Peak throughput is one frame per 5 cycles.
- Arithmetic, with j multiply (a+jb)·j = −b+ja exact by swap/negate (no multiplier):
  - x0 = X0+X1+X2+X3
  - x1 = X0+jX1−X2−jX3
  - x2 = X0−X1+X2−X3
  - x3 = X0−jX1−X2+jX3
- Width rules:
  - Sums are formed in IN_W+2 (20) bits, so there is no internal overflow.
  - Scaling is an arithmetic shift right by SCALE_SHIFT (floor, no rounding), giving 18 bits.
  - Result is saturated to OUT_W: >32767→32767, <−32768→−32768.
  - Any saturating component sets sat_flag at the transfer edge.
- err_frame is set when either:
  - an accept has in_last=1 with k_cnt≠3, or
  - an accept has in_last=0 with k_cnt=3.
  Framing still follows k_cnt; in_last never resynchronises.
- Sticky flags clear only on reset.

Test Plan:
- DC bin: X0=(4,0), X1..X3=0, out_ready=1 → four samples all 0x00000001, out_last on 4th, first out_valid one cycle after the 4th bin accept.
- Single-bin rotation: X1=(4,0), others 0 → x0=0x00000001, x1=0x00010000, x2=0x0000FFFF, x3=0xFFFF0000.
- Floor + saturation:
  - X0=(−1,0), others 0 → all samples real=0xFFFF (floor of −1/4 = −1).
  - All four bins real=0x1FFFF → x0 real=0x7FFF, x1..x3=0, sat_flag=1.
- Backpressure: out_ready=0 for 10 cycles after frame 1, frame 2 streamed continuously → frame 2 enters HOLD, in_ready=0 until frame 1 drains; data held stable; frame 2 outputs follow with no bubble when drain and transfer coincide; no data loss.
- Framing error: in_last=1 on 2nd bin → err_frame=1 next cycle and stays 1; the frame still completes after 4 accepts.
- Reset mid-frame: rstn=0 for one edge after 2 bins accepted → all outputs 0, next 4 bins form a clean frame with correct results.
